// File: rtl/selector_casilla.sv
// Cursor/selection front end for the tic-tac-toe board: button conditioning,
// wrap-around (X,Y) cursor and move confirmation against board occupancy.
module selector_casilla #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned N_POS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_der,
  input  logic       btn_izq,
  input  logic       btn_arr,
  input  logic       btn_aba,
  input  logic       btn_ok,
  input  logic       habilitado,
  input  logic       casilla_ocupada,
  output logic [2:0] valorX,
  output logic [2:0] valorY,
  output logic       jugada_valida,
  output logic       jugada_rechazada,
  output logic       turno
);

  localparam int unsigned NB = 5;
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PW = 3;
  localparam logic [PW-1:0] POS_MAX = PW'(N_POS - 1);

  // Button bit positions, also the service priority (lowest index wins)
  localparam int unsigned B_OK  = 0;
  localparam int unsigned B_DER = 1;
  localparam int unsigned B_IZQ = 2;
  localparam int unsigned B_ARR = 3;
  localparam int unsigned B_ABA = 4;

  typedef enum logic [1:0] {
    LIBRE    = 2'd0,
    CONFIRMA = 2'd1,
    BLOQUEO  = 2'd2
  } estado_t;

  logic [NB-1:0]         btn_raw;
  logic [NB-1:0]         sync1_q, sync1_d;
  logic [NB-1:0]         sync2_q, sync2_d;
  logic [NB-1:0]         lvl_q, lvl_d;
  logic [NB-1:0]         lvl_dly_q, lvl_dly_d;
  logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NB-1:0]         ev_c;

  estado_t               estado_q, estado_d;
  logic [PW-1:0]         x_q, x_d;
  logic [PW-1:0]         y_q, y_d;
  logic                  turno_q, turno_d;
  logic                  valida_q, valida_d;
  logic                  rechazada_q, rechazada_d;

  assign btn_raw = {btn_aba, btn_arr, btn_izq, btn_der, btn_ok};

  // Synchronise and debounce every button; level flips after DEB_CYCLES differing samples
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    lvl_d     = lvl_q;
    lvl_dly_d = lvl_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
        lvl_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // One-cycle event on each debounced rising edge
  assign ev_c = lvl_q & ~lvl_dly_q;

  // Cursor movement, confirm sequencing and turn tracking
  always_comb begin
    estado_d    = estado_q;
    x_d         = x_q;
    y_d         = y_q;
    turno_d     = turno_q;
    valida_d    = 1'b0;
    rechazada_d = 1'b0;
    if (!habilitado) begin
      estado_d = LIBRE;
    end else begin
      case (estado_q)
        LIBRE: begin
          if (ev_c[B_OK]) begin
            estado_d = CONFIRMA;
          end else if (ev_c[B_DER]) begin
            x_d = (x_q == POS_MAX) ? '0 : x_q + PW'(1);
          end else if (ev_c[B_IZQ]) begin
            x_d = (x_q == '0) ? POS_MAX : x_q - PW'(1);
          end else if (ev_c[B_ARR]) begin
            y_d = (y_q == '0) ? POS_MAX : y_q - PW'(1);
          end else if (ev_c[B_ABA]) begin
            y_d = (y_q == POS_MAX) ? '0 : y_q + PW'(1);
          end
        end
        CONFIRMA: begin
          if (casilla_ocupada) begin
            rechazada_d = 1'b1;
          end else begin
            valida_d = 1'b1;
            turno_d  = ~turno_q;
          end
          estado_d = BLOQUEO;
        end
        BLOQUEO: begin
          if (!lvl_q[B_OK]) begin
            estado_d = LIBRE;
          end
        end
        default: estado_d = LIBRE;
      endcase
    end
  end

  // State register for conditioning, FSM and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lvl_q       <= '0;
      lvl_dly_q   <= '0;
      cnt_q       <= '0;
      estado_q    <= LIBRE;
      x_q         <= '0;
      y_q         <= '0;
      turno_q     <= 1'b0;
      valida_q    <= 1'b0;
      rechazada_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      lvl_q       <= lvl_d;
      lvl_dly_q   <= lvl_dly_d;
      cnt_q       <= cnt_d;
      estado_q    <= estado_d;
      x_q         <= x_d;
      y_q         <= y_d;
      turno_q     <= turno_d;
      valida_q    <= valida_d;
      rechazada_q <= rechazada_d;
    end
  end

  assign valorX           = x_q;
  assign valorY           = y_q;
  assign jugada_valida    = valida_q;
  assign jugada_rechazada = rechazada_q;
  assign turno            = turno_q;

endmodule
